// File: rtl/ts4231_config_scheduler.sv
// ts4231_config_scheduler
// Time-shares one ts4231 configuration engine across several light sensors.
// Each sensor gets a reset pulse, then a bounded wait for the configured code.
// Failed attempts are retried a fixed number of times, and the final outcome
// for every sensor is recorded. All outputs are registered from the
// next-state logic.
module ts4231_config_scheduler #(
    parameter int          NUMBER_OF_SENSORS = 2,
    parameter int          CLK_FREQ          = 16_000_000,
    parameter int          TIMEOUT_MS        = 100,
    parameter int          RST_CYCLES        = 4,
    parameter int          MAX_RETRIES       = 3,
    parameter logic [2:0]  CONFIGURED_CODE   = 3'd4,
    parameter int          SEL_W             = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           continuous,
    input  logic [2:0]                     engine_state,
    output logic                           engine_rst,
    output logic [SEL_W-1:0]               engine_sel,
    output logic                           busy,
    output logic                           done,
    output logic [NUMBER_OF_SENSORS-1:0]   configured,
    output logic [NUMBER_OF_SENSORS-1:0]   failed,
    output logic [3*NUMBER_OF_SENSORS-1:0] sensor_states
);

    localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ / 1000) * TIMEOUT_MS;
    localparam int          RETRY_W        = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [31:0]        TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]        RST_LAST   = 32'(RST_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [SEL_W-1:0]   LAST_SEL   = SEL_W'(NUMBER_OF_SENSORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT,
        S_RECORD,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [31:0]                    rst_cnt_q, rst_cnt_d;
    logic [31:0]                    timer_q, timer_d;
    logic [RETRY_W-1:0]             retry_q, retry_d;
    logic [SEL_W-1:0]               sel_d;
    logic                           match_q, match_d;
    logic                           succ_q, succ_d;
    logic                           engine_rst_d, busy_d, done_d;
    logic [NUMBER_OF_SENSORS-1:0]   cfg_d, fail_d;
    logic [3*NUMBER_OF_SENSORS-1:0] ss_d;
    logic                           match_now;

    assign match_now = (engine_state == CONFIGURED_CODE);

    // Next-state, counters, per-sensor records and registered-output decode
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        sel_d     = engine_sel;
        match_d   = 1'b0;
        succ_d    = succ_q;
        cfg_d     = configured;
        fail_d    = failed;
        ss_d      = sensor_states;

        case (state_q)
            S_IDLE: begin
                if (start || continuous) begin
                    state_d   = S_RST;
                    sel_d     = '0;
                    retry_d   = '0;
                    cfg_d     = '0;
                    fail_d    = '0;
                    rst_cnt_d = '0;
                end
            end
            S_RST: begin
                succ_d = 1'b0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = S_WAIT;
                    rst_cnt_d = '0;
                    timer_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 32'd1;
                match_d = match_now;
                // Two back-to-back matches filter single-cycle glitches;
                // success is checked first so it wins over a same-cycle timeout.
                if (match_now && match_q) begin
                    succ_d  = 1'b1;
                    state_d = S_RECORD;
                end else if (timer_q == TIMER_LAST) begin
                    succ_d  = 1'b0;
                    state_d = S_RECORD;
                end
            end
            S_RECORD: begin
                for (int i = 0; i < NUMBER_OF_SENSORS; i++) begin
                    if (engine_sel == SEL_W'(i)) begin
                        ss_d[3*i +: 3] = engine_state;
                        if (succ_q)
                            cfg_d[i] = 1'b1;
                        else if (retry_q == RETRY_MAX)
                            fail_d[i] = 1'b1;
                    end
                end
                if (succ_q) begin
                    state_d = S_NEXT;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d   = retry_q + 1'b1;
                    rst_cnt_d = '0;
                    state_d   = S_RST;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (engine_sel == LAST_SEL) begin
                    state_d = S_DONE;
                end else begin
                    sel_d     = engine_sel + 1'b1;
                    retry_d   = '0;
                    rst_cnt_d = '0;
                    state_d   = S_RST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered, so they line up with it
        engine_rst_d = (state_d == S_IDLE) || (state_d == S_RST) || (state_d == S_DONE);
        busy_d       = (state_d == S_RST) || (state_d == S_WAIT) ||
                       (state_d == S_RECORD) || (state_d == S_NEXT);
        done_d       = (state_d == S_DONE);
    end

    // State, counters and all outputs; reset aborts any pass in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            timer_q       <= '0;
            retry_q       <= '0;
            match_q       <= 1'b0;
            succ_q        <= 1'b0;
            engine_rst    <= 1'b1;
            engine_sel    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            configured    <= '0;
            failed        <= '0;
            sensor_states <= '0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            timer_q       <= timer_d;
            retry_q       <= retry_d;
            match_q       <= match_d;
            succ_q        <= succ_d;
            engine_rst    <= engine_rst_d;
            engine_sel    <= sel_d;
            busy          <= busy_d;
            done          <= done_d;
            configured    <= cfg_d;
            failed        <= fail_d;
            sensor_states <= ss_d;
        end
    end

endmodule
